// File: rtl/move_fsm_n.sv
// Round-robin debounced button scanner that emits one-cycle move strobes and
// latches a sticky DONE on flag. Define MOVE_FSM_PRIO_EN for lowest-index-wins scan.
module move_fsm_n #(
   parameter int N_BTN          = 4,
   parameter bit BTN_ACTIVE_LOW = 1'b1,
   parameter int HOLD_CYC       = 4,
   parameter int CNT_W          = 8,
   localparam int IDX_W         = $clog2(N_BTN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn,
   input  logic             flag,
   input  logic             restart,
   output logic             move_valid,
   output logic [IDX_W-1:0] move_dir,
   output logic [CNT_W-1:0] move_count,
   output logic             done,
   output logic [2:0]       state_o
);

   localparam int HC_W = $clog2(HOLD_CYC + 1);

   localparam logic [2:0] S_SCAN = 3'd0;
   localparam logic [2:0] S_HOLD = 3'd1;
   localparam logic [2:0] S_MOVE = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] scan_q, scan_d;
   logic [IDX_W-1:0] cand_q, cand_d;
   logic [HC_W-1:0]  hc_q, hc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N_BTN-1:0] act;
   logic             scan_hit;
   logic [IDX_W-1:0] scan_pick, scan_miss, rr_next;

   assign act = BTN_ACTIVE_LOW ? ~btn : btn;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(N_BTN - 1)) ? '0 : i + 1'b1;
   endfunction

`ifdef MOVE_FSM_PRIO_EN
   // Descending walk so the lowest pressed index is the last one written.
   always_comb begin
      scan_hit  = 1'b0;
      scan_pick = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (act[i]) begin
            scan_hit  = 1'b1;
            scan_pick = IDX_W'(i);
         end
      end
   end
   assign scan_miss = '0;
   assign rr_next   = '0;
`else
   assign scan_hit  = act[scan_q];
   assign scan_pick = scan_q;
   assign scan_miss = wrap_inc(scan_q);
   assign rr_next   = wrap_inc(cand_q);
`endif

   always_comb begin
      state_d = state_q;
      scan_d  = scan_q;
      cand_d  = cand_q;
      hc_d    = hc_q;
      cnt_d   = cnt_q;
      if (restart) begin
         state_d = S_SCAN;
         scan_d  = '0;
         hc_d    = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_SCAN: begin
               if (scan_hit) begin
                  cand_d = scan_pick;
                  if (HOLD_CYC == 1) begin
                     state_d = S_MOVE;
                  end else begin
                     state_d = S_HOLD;
                     hc_d    = HC_W'(1);
                  end
               end else begin
                  scan_d = scan_miss;
               end
            end
            S_HOLD: begin
               if (act[cand_q]) begin
                  hc_d = hc_q + 1'b1;
                  if (hc_q == HC_W'(HOLD_CYC - 1)) state_d = S_MOVE;
               end else begin
                  state_d = S_SCAN;
                  scan_d  = rr_next;
               end
            end
            S_MOVE: begin
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               state_d = flag ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
               if (flag) begin
                  state_d = S_DONE;
               end else if (act == '0) begin
                  state_d = S_SCAN;
                  scan_d  = rr_next;
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_SCAN;
         scan_q  <= '0;
         cand_q  <= '0;
         hc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         scan_q  <= scan_d;
         cand_q  <= cand_d;
         hc_q    <= hc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Restart suppresses the strobe even when it coincides with MOVE.
   assign move_valid = (state_q == S_MOVE) && !restart;
   assign move_dir   = move_valid ? cand_q : '0;
   assign move_count = cnt_q;
   assign done       = (state_q == S_DONE);
   assign state_o    = state_q;

endmodule

// File: tb/tb_move_fsm_n.sv
// Self-checking bench for move_fsm_n: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the movement rules.
module tb_move_fsm_n;
   localparam int N   = 4;
   localparam int HC  = 4;
   localparam int CW  = 3;
   localparam int IW  = $clog2(N);
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  btn;
   logic          flag, restart;
   logic          move_valid;
   logic [IW-1:0] move_dir;
   logic [CW-1:0] move_count;
   logic          done;
   logic [2:0]    state_o;

   move_fsm_n #(.N_BTN(N), .BTN_ACTIVE_LOW(1'b1), .HOLD_CYC(HC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .btn(btn), .flag(flag), .restart(restart),
      .move_valid(move_valid), .move_dir(move_dir), .move_count(move_count),
      .done(done), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int errs = 0, checks = 0;
   // Model: phase uses the published state codes; held = cycles the candidate has been seen pressed.
   int m_st, m_si, m_cand, m_held, m_cnt;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit pressed(input int i);
      return btn[i] == 1'b0;
   endfunction

   function automatic bit any_pressed();
      return btn != '1;
   endfunction

   task automatic m_reset();
      m_st = 0; m_si = 0; m_cand = 0; m_held = 0; m_cnt = 0;
   endtask

   task automatic m_step();
      if (restart) begin
         m_st = 0; m_si = 0; m_held = 0; m_cnt = 0;
         return;
      end
      case (m_st)
         0: begin
            int pick = -1;
`ifdef MOVE_FSM_PRIO_EN
            for (int i = N - 1; i >= 0; i--) if (pressed(i)) pick = i;
`else
            if (pressed(m_si)) pick = m_si;
            else m_si = (m_si + 1) % N;
`endif
            if (pick >= 0) begin
               m_cand = pick;
               m_held = 1;
               m_st = (HC == 1) ? 2 : 1;
            end
         end
         1: begin
            if (pressed(m_cand)) begin
               m_held++;
               if (m_held == HC) m_st = 2;
            end else begin
               m_st = 0;
`ifdef MOVE_FSM_PRIO_EN
               m_si = 0;
`else
               m_si = (m_cand + 1) % N;
`endif
            end
         end
         2: begin
            m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
            m_st = flag ? 4 : 3;
         end
         3: begin
            if (flag) m_st = 4;
            else if (!any_pressed()) begin
               m_st = 0;
`ifdef MOVE_FSM_PRIO_EN
               m_si = 0;
`else
               m_si = (m_cand + 1) % N;
`endif
            end
         end
         4: m_st = 4;
         default: m_st = 0;
      endcase
   endtask

   task automatic compare();
      bit ev;
      ev = (m_st == 2) && !restart;
      chk("state", state_o, m_st);
      chk("valid", move_valid, ev);
      if (ev) chk("dir", move_dir, m_cand);
      chk("count", move_count, m_cnt);
      chk("done", done, m_st == 4);
   endtask

   // Called at a negedge with inputs already applied; returns at the next negedge.
   task automatic tick();
      #1 compare();
      @(posedge clk);
      m_step();
      @(negedge clk);
   endtask

   task automatic press_at(input int idx);
      for (int k = 0; k < 2 * N && !(m_st == 0 && m_si == idx); k++) tick();
      chk("press_align", m_st * 16 + m_si, idx);
      btn = '1;
      btn[idx] = 1'b0;
   endtask

   initial begin
      int dur;
      rst = 1'b0; btn = '1; flag = 1'b0; restart = 1'b0;
      m_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_state", state_o, 0);
      chk("rst_valid", move_valid, 0);
      chk("rst_count", move_count, 0);
      chk("rst_done", done, 0);
      chk("rst_dir", move_dir, 0);

      // Idle scan
      repeat (20) tick();

      // Accepted press on channel 2 with fixed latency
      press_at(2);
      repeat (HC) tick();
      #1;
      chk("lat_valid", move_valid, 1);
      chk("lat_dir", move_dir, 2);
      repeat (3) tick();
      chk("wait_rel", state_o, 3);
      btn = '1;
      tick();
      chk("count_one", move_count, 1);

      // Bounce on channel 1: too short to accept
      press_at(1);
      repeat (2) tick();
      btn = '1;
      repeat (6) tick();
      chk("bounce_count", move_count, 1);

      // Move with flag set during MOVE -> sticky DONE
      press_at(0);
      repeat (HC) tick();
      flag = 1'b1;
      tick();
      flag = 1'b0;
      #1 chk("done_hi", done, 1);
      btn = '0;
      repeat (8) tick();
      btn = '1;
      chk("done_stuck", state_o, 4);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      #1;
      chk("restart_cnt", move_count, 0);
      chk("restart_done", done, 0);

      // Counter saturation
      for (int mv = 0; mv < MAXC + 2; mv++) begin
         press_at(m_si);
         repeat (HC + 1) tick();
         btn = '1;
         repeat (2) tick();
         chk("sat_count", move_count, (mv + 1 < MAXC) ? mv + 1 : MAXC);
      end

      // Restart coinciding with MOVE suppresses the strobe
      press_at(m_si);
      repeat (HC) tick();
      restart = 1'b1;
      #1 chk("restart_move_valid", move_valid, 0);
      tick();
      restart = 1'b0;
      btn = '1;
      repeat (2) tick();

      // Async reset mid-HOLD and mid-MOVE
      for (int r = 0; r < 2; r++) begin
         press_at(m_si);
         repeat (r == 0 ? 2 : HC) tick();
         #2 rst = 1'b0;
         #1;
         chk("arst_state", state_o, 0);
         chk("arst_valid", move_valid, 0);
         chk("arst_count", move_count, 0);
         m_reset();
         @(negedge clk);
         rst = 1'b1;
         btn = '1;
         repeat (3) tick();
      end

      // Random traffic
      dur = 0;
      for (int c = 0; c < 3000; c++) begin
         if (dur == 0) begin
            int sel;
            sel = $urandom_range(0, 9);
            dur = $urandom_range(1, 9);
            if (sel < 5) btn = '1;
            else if (sel < 9) begin
               btn = '1;
               btn[$urandom_range(0, N - 1)] = 1'b0;
            end else btn = N'($urandom);
         end
         dur--;
         flag    = ($urandom_range(0, 39) == 0);
         restart = ($urandom_range(0, 79) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule
